// File: rtl/mdu_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_ctrl -- sequencing controller for the E-stage multiply/divide unit.
//
// Accepts an MDU operation from E, computes its result into pending HI/LO
// registers at issue, then holds the unit busy for a fixed number of cycles
// before committing the pending value to HI/LO. Also produces the D-stage
// stall and the MFHI/MFLO read data.
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst    in   1  asynchronous reset, active-low
//   Req    in   1  exception request; cancels any issue in the same cycle
//   start  in   1  E-stage instruction is an MDU op
//   op     in   4  1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//                  7 MFHI, 8 MFLO, anything else NONE
//   E_rs   in  32  forwarded rs operand
//   E_rt   in  32  forwarded rt operand
//   D_MD   in   1  D-stage instruction is an MDU instruction
//   busy   out  1  multi-cycle operation in flight
//   stall  out  1  freeze F/D, bubble into E
//   HI     out 32  HI register
//   LO     out 32  LO register
//   E_HL   out 32  MFHI/MFLO read data
// ---------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Req,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] E_rs,
    input  logic [31:0] E_rt,
    input  logic        D_MD,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] E_HL
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [31:0]        r_hi, r_lo, w_hi_nxt, w_lo_nxt;
    logic [31:0]        r_phi, r_plo, w_phi_nxt, w_plo_nxt;

    logic               w_issue;
    logic               w_md_long;
    logic [63:0]        w_mul_a, w_mul_b, w_prod;
    logic [63:0]        w_div_res;
    logic [31:0]        w_div_rt;

    // Division done on magnitudes so that the 0x80000000 / -1 case wraps
    // cleanly to 0x80000000 instead of relying on simulator overflow rules.
    // Returns {remainder, quotient}; b must be non-zero.
    function automatic logic [63:0] f_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic [31:0] ua, ub, q, r;
        ua = (sgn && a[31]) ? (32'd0 - a) : a;
        ub = (sgn && b[31]) ? (32'd0 - b) : b;
        q  = ua / ub;
        r  = ua % ub;
        if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
        if (sgn && a[31])           r = 32'd0 - r;
        return {r, q};
    endfunction

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // then correct for both signed and unsigned multiplication.
    assign w_mul_a = (op == OP_MULT) ? {{32{E_rs[31]}}, E_rs} : {32'd0, E_rs};
    assign w_mul_b = (op == OP_MULT) ? {{32{E_rt[31]}}, E_rt} : {32'd0, E_rt};
    assign w_prod  = w_mul_a * w_mul_b;

    // Keep the divider away from a zero divisor; the result is discarded then.
    assign w_div_rt  = (E_rt == 32'd0) ? 32'd1 : E_rt;
    assign w_div_res = f_div(E_rs, w_div_rt, op == OP_DIV);

    assign w_issue   = start & ~Req & (r_state == S_IDLE);
    assign w_md_long = (op == OP_MULT) || (op == OP_MULTU) ||
                       (op == OP_DIV)  || (op == OP_DIVU);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_phi_nxt   = r_phi;
        w_plo_nxt   = r_plo;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            w_phi_nxt   = w_prod[63:32];
                            w_plo_nxt   = w_prod[31:0];
                            w_cnt_nxt   = CNT_W'(MULT_CYCLES);
                            w_state_nxt = S_BUSY;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (E_rt == 32'd0) begin
                                w_phi_nxt = r_hi;
                                w_plo_nxt = r_lo;
                            end else begin
                                w_phi_nxt = w_div_res[63:32];
                                w_plo_nxt = w_div_res[31:0];
                            end
                            w_cnt_nxt   = CNT_W'(DIV_CYCLES);
                            w_state_nxt = S_BUSY;
                        end
                        OP_MTHI: w_hi_nxt = E_rs;
                        OP_MTLO: w_lo_nxt = E_rs;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (r_cnt > CNT_W'(1)) begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end else begin
                    w_hi_nxt    = r_phi;
                    w_lo_nxt    = r_plo;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_phi   <= w_phi_nxt;
            r_plo   <= w_plo_nxt;
        end
    end

    assign busy  = (r_state == S_BUSY);
    assign stall = D_MD & (busy | (start & ~Req & w_md_long));
    assign HI    = r_hi;
    assign LO    = r_lo;
    // No bypass of a same-cycle MTHI/MTLO: reads see the registered value.
    assign E_HL  = (op == OP_MFHI) ? r_hi :
                   (op == OP_MFLO) ? r_lo : 32'd0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mdu_ctrl -- directed bench for mdu_ctrl with hand-computed expectations.
// Inputs change 1 ns after a rising edge; outputs are checked before the
// next rising edge.
// ---------------------------------------------------------------------------
module tb_mdu_ctrl;

    logic        clk;
    logic        rst;
    logic        Req;
    logic        start;
    logic [3:0]  op;
    logic [31:0] E_rs;
    logic [31:0] E_rt;
    logic        D_MD;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] E_HL;

    int checks   = 0;
    int failures = 0;

    // Expected architectural HI/LO, maintained by the bench.
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .rst   (rst),
        .Req   (Req),
        .start (start),
        .op    (op),
        .E_rs  (E_rs),
        .E_rt  (E_rt),
        .D_MD  (D_MD),
        .busy  (busy),
        .stall (stall),
        .HI    (HI),
        .LO    (LO),
        .E_HL  (E_HL)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multi-cycle op and walk through its busy window.
    // req_at: busy cycle index (0-based) in which Req pulses, -1 for none.
    task automatic run_op(input string tag, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic dmd, input int req_at,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        start = 1'b1; op = o; E_rs = a; E_rt = b; D_MD = dmd; Req = 1'b0;
        #1;
        chk({tag, "_issue_stall"}, {31'd0, stall}, {31'd0, dmd});
        tick();
        start = 1'b0; op = 4'd0;
        for (int i = 0; i < n; i++) begin
            Req = (i == req_at);
            #1;
            chk({tag, "_busy"},  {31'd0, busy},  32'd1);
            chk({tag, "_stall"}, {31'd0, stall}, {31'd0, dmd});
            if (i == n - 1) begin
                chk({tag, "_hi_hold"}, HI, m_hi);
                chk({tag, "_lo_hold"}, LO, m_lo);
            end
            tick();
        end
        Req = 1'b0;
        #1;
        chk({tag, "_done_busy"},  {31'd0, busy},  32'd0);
        chk({tag, "_done_stall"}, {31'd0, stall}, 32'd0);
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
        m_hi = exp_hi;
        m_lo = exp_lo;
        D_MD = 1'b0;
    endtask

    initial begin
        rst = 1'b0; Req = 1'b0; start = 1'b0; op = 4'd0;
        E_rs = 32'd0; E_rt = 32'd0; D_MD = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;

        // Reset state
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        #22 rst = 1'b1;
        tick();

        // MULT -2 * 3, stall held for issue + 5 busy cycles
        run_op("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5, 1'b1, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        // MULTU same operands, no D-stage MDU so never stall
        run_op("multu", 4'd2, 32'hFFFF_FFFE, 32'd3, 5, 1'b0, -1, 32'h0000_0002, 32'hFFFF_FFFA);
        // DIV -7 / 2 -> q=-3, r=-1
        run_op("div", 4'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b0, -1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        // DIVU 7 / 2 -> q=3, r=1
        run_op("divu", 4'd4, 32'd7, 32'd2, 10, 1'b0, -1, 32'd1, 32'd3);
        // DIVU by zero keeps HI/LO but still takes the full time
        run_op("divu0", 4'd4, 32'd7, 32'd0, 10, 1'b0, -1, 32'd1, 32'd3);
        // Signed overflow case
        run_op("divovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0, -1, 32'd0, 32'h8000_0000);

        // Req cancels a MULT issue
        start = 1'b1; op = 4'd1; E_rs = 32'd9; E_rt = 32'd9; Req = 1'b1; D_MD = 1'b1;
        #1;
        chk("req_mult_stall", {31'd0, stall}, 32'd0);
        tick();
        chk("req_mult_busy", {31'd0, busy}, 32'd0);
        chk("req_mult_hi", HI, m_hi);
        chk("req_mult_lo", LO, m_lo);
        // Req cancels MTHI
        op = 4'd5; E_rs = 32'h0000_1234; D_MD = 1'b0;
        tick();
        chk("req_mthi_hi", HI, m_hi);
        // MTHI without Req
        Req = 1'b0;
        tick();
        m_hi = 32'h0000_1234;
        chk("mthi_hi", HI, m_hi);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        start = 1'b0;
        op = 4'd7; #1;
        chk("mfhi_ehl", E_HL, 32'h0000_1234);
        op = 4'd8; #1;
        chk("mflo_ehl", E_HL, 32'h8000_0000);
        op = 4'd3; #1;
        chk("none_ehl", E_HL, 32'd0);
        tick();

        // Req pulse in busy cycle 4 does not disturb DIV 100 / -7 -> q=-14, r=2
        run_op("divreq", 4'd3, 32'd100, 32'hFFFF_FFF9, 10, 1'b1, 3, 32'd2, 32'hFFFF_FFF2);

        // Async reset in busy cycle 3
        start = 1'b1; op = 4'd1; E_rs = 32'd5; E_rt = 32'd6;
        tick();
        start = 1'b0; op = 4'd0;
        tick();
        tick();
        chk("arst_pre_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", HI, 32'd0);
        chk("arst_lo", LO, 32'd0);
        #1 rst = 1'b1;
        tick();
        tick();
        chk("arst_after_busy", {31'd0, busy}, 32'd0);
        chk("arst_after_lo", LO, 32'd0);

        // MTLO then MFLO
        start = 1'b1; op = 4'd6; E_rs = 32'hA5A5_A5A5;
        #1;
        chk("mtlo_nobypass", E_HL, 32'd0);
        tick();
        op = 4'd8;
        #1;
        chk("mflo_after_mtlo", E_HL, 32'hA5A5_A5A5);
        chk("mtlo_hi", HI, 32'd0);
        start = 1'b0; op = 4'd0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencing controller for the multiply/divide unit in the E stage of the P7 pipeline.
- Accepts MDU operations from the E stage, models the fixed multi-cycle latency with a busy counter, and owns the HI/LO registers.
- Drives the D-stage stall so that no MDU instruction issues while an operation is in flight.
- Honours the exception request `Req`, which flushes the pipeline registers: an MDU operation issued in the same cycle as `Req` never starts.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-low
- Req  input  1  exception/interrupt request; synchronous cancel of E-stage issue
- start  input  1  E-stage instruction is an MDU op, qualified by `op`
- op  input  4  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MFHI, 8 MFLO; 9-15 treated as NONE
- E_rs  input  32  forwarded rs operand
- E_rt  input  32  forwarded rt operand
- D_MD  input  1  D-stage instruction is any MDU instruction (ops 1-8)
- busy  output  1  operation in flight
- stall  output  1  freeze F/D and insert bubble into E
- HI  output  32  HI register
- LO  output  32  LO register
- E_HL  output  32  MFHI/MFLO read data, for the E/M register

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, HI=0, LO=0, pending HI/LO=0, busy=0. Reset takes priority over everything, including mid-operation; the in-flight result is discarded.
- States:
  - IDLE: busy=0.
  - BUSY: busy=1; cnt holds the remaining cycles.
- Issue: at a rising edge with state=IDLE, start=1, Req=0:
  - op 1/2 (MULT/MULTU):
    - Compute the 64-bit product, signed for MULT and unsigned for MULTU, into pending registers.
    - cnt<=MULT_CYCLES; state<=BUSY.
  - op 3/4 (DIV/DIVU):
    - Compute pending LO=quotient and HI=remainder, signed (truncate toward zero, remainder takes the dividend's sign) or unsigned.
    - cnt<=DIV_CYCLES; state<=BUSY.
    - Divisor 0: pending value = current HI/LO, so the registers are unchanged; the full busy time still elapses.
  - op 5 (MTHI): HI<=E_rs at that edge; no busy.
  - op 6 (MTLO): LO<=E_rs at that edge; no busy.
  - ops 0, 7, 8: no state change.
- BUSY, each edge:
  - cnt>1: cnt<=cnt-1.
  - cnt==1: HI/LO<=pending; state<=IDLE.
  - Result visible on HI/LO in the cycle after the last busy cycle.
  - Latency: issue edge to HI/LO update = N+1 edges; busy is high for exactly N cycles.
- Req=1 at an edge: any issue (ops 1-6) in that cycle is suppressed. An operation already in BUSY is unaffected and completes.
- start=1 while BUSY: ignored; HI/LO and cnt are unchanged. The stall logic prevents this from occurring.
- E_HL (combinational):
  - op==7: HI.
  - op==8: LO.
  - else: 0.
  - Reads current register values; an MTHI/MTLO result is not bypassed within the same cycle.
- stall (combinational) = D_MD & (busy | (start & ~Req & op in 1..4)).
- Widths: all arithmetic is on 32-bit operands with 64-bit intermediate products. Quotient and remainder are 32 bits each. Signed DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0.

Test Plan:
- Reset then MULT with E_rs=0xFFFFFFFE (-2), E_rt=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU on the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV with E_rs=-7 (0xFFFFFFF9), E_rt=2 -> busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with E_rs=7, E_rt=2 -> LO=3, HI=1; DIVU with E_rt=0 -> HI/LO unchanged after 10 busy cycles.
- Stall: D_MD=1 during the MULT issue cycle and all 5 busy cycles -> stall=1 for exactly 6 cycles; D_MD=0 -> stall=0 throughout.
- Req cancel: start=1, op=MULT, Req=1 at the same edge -> busy stays 0 and HI/LO unchanged; MTHI with E_rs=0x1234 and Req=1 -> HI unchanged.
- Req mid-operation: DIV issued, Req pulses in busy cycle 4 -> the operation still completes after 10 cycles with the correct result.
- Async reset mid-operation: rst=0 in busy cycle 3 between clock edges -> busy=0, HI=LO=0 immediately; MTLO 0xA5A5A5A5 followed by MFLO -> E_HL=0xA5A5A5A5.
